// File: rtl/ltm_display_reader.sv
// LCD panel timing generator that streams RGB pixels out of a display FIFO.
// Sync/DE decodes are delayed two clocks so they line up with the registered FIFO data.
module ltm_display_reader #(
    parameter int H_ACTIVE = 800,
    parameter int H_FRONT  = 210,
    parameter int H_SYNC   = 1,
    parameter int H_BACK   = 45,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 22,
    parameter int V_SYNC   = 1,
    parameter int V_BACK   = 22
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [23:0] DISP_FIFO_OUT,
    input  logic        DISP_FIFO_EMPTY,
    output logic        DISP_FIFO_RD,
    output logic [7:0]  oLCD_R,
    output logic [7:0]  oLCD_G,
    output logic [7:0]  oLCD_B,
    output logic        oHD,
    output logic        oVD,
    output logic        oDEN,
    output logic        oFRAME_START,
    output logic        oUNDERFLOW
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT_END  = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] H_SYNC_BEG = H_W'(H_ACTIVE + H_FRONT);
    localparam logic [H_W-1:0] H_SYNC_END = H_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACT_END  = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] V_SYNC_BEG = V_W'(V_ACTIVE + V_FRONT);
    localparam logic [V_W-1:0] V_SYNC_END = V_W'(V_ACTIVE + V_FRONT + V_SYNC);

    typedef enum logic [1:0] {
        WAIT_FIFO = 2'd0,
        RUN       = 2'd1,
        RESYNC    = 2'd2
    } state_t;

    logic [H_W-1:0] r_h_cnt;
    logic [V_W-1:0] r_v_cnt;
    state_t         r_state;
    state_t         w_state_nx;

    logic w_active;
    logic w_hd_n;
    logic w_vd_n;
    logic w_frame_start;
    logic w_frame_end;
    logic w_rd;
    logic w_underflow_evt;

    logic r_rd_d1;
    logic r_hd_p1;
    logic r_vd_p1;
    logic r_den_p1;
    logic r_fs_p1;

    // Stage p0: raster counters and position decodes
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + V_W'(1);
        end else begin
            r_h_cnt <= r_h_cnt + H_W'(1);
        end
    end

    assign w_active      = (r_h_cnt < H_ACT_END) && (r_v_cnt < V_ACT_END);
    assign w_hd_n        = !((r_h_cnt >= H_SYNC_BEG) && (r_h_cnt < H_SYNC_END));
    assign w_vd_n        = !((r_v_cnt >= V_SYNC_BEG) && (r_v_cnt < V_SYNC_END));
    assign w_frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign w_frame_end   = (r_h_cnt == H_LAST) && (r_v_cnt == V_LAST);

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state <= WAIT_FIFO;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Streaming only (re)starts on a frame boundary so the panel never sees a torn frame.
    always_comb begin
        w_state_nx      = r_state;
        w_rd            = 1'b0;
        w_underflow_evt = 1'b0;
        case (r_state)
            WAIT_FIFO: begin
                if (w_frame_end && !DISP_FIFO_EMPTY) begin
                    w_state_nx = RUN;
                end
            end
            RUN: begin
                if (w_active) begin
                    if (DISP_FIFO_EMPTY) begin
                        w_underflow_evt = 1'b1;
                        w_state_nx      = RESYNC;
                    end else begin
                        w_rd = 1'b1;
                    end
                end
            end
            RESYNC: begin
                if (w_frame_end && !DISP_FIFO_EMPTY) begin
                    w_state_nx = RUN;
                end
            end
            default: begin
                w_state_nx = WAIT_FIFO;
            end
        endcase
    end

    // Gated with reset so no read is issued while the state register is being cleared.
    assign DISP_FIFO_RD = w_rd && RESET_N;

    // Stage p1: read strobe and decodes registered while FIFO presents data
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_rd_d1  <= 1'b0;
            r_hd_p1  <= 1'b1;
            r_vd_p1  <= 1'b1;
            r_den_p1 <= 1'b0;
            r_fs_p1  <= 1'b0;
        end else begin
            r_rd_d1  <= DISP_FIFO_RD;
            r_hd_p1  <= w_hd_n;
            r_vd_p1  <= w_vd_n;
            r_den_p1 <= w_active;
            r_fs_p1  <= w_frame_start;
        end
    end

    // Stage p2: panel outputs; colour blanks whenever no read backed this pixel
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            oHD          <= 1'b1;
            oVD          <= 1'b1;
            oDEN         <= 1'b0;
            oFRAME_START <= 1'b0;
            oLCD_R       <= 8'h00;
            oLCD_G       <= 8'h00;
            oLCD_B       <= 8'h00;
            oUNDERFLOW   <= 1'b0;
        end else begin
            oHD          <= r_hd_p1;
            oVD          <= r_vd_p1;
            oDEN         <= r_den_p1;
            oFRAME_START <= r_fs_p1;
            if (r_rd_d1) begin
                oLCD_R <= DISP_FIFO_OUT[23:16];
                oLCD_G <= DISP_FIFO_OUT[15:8];
                oLCD_B <= DISP_FIFO_OUT[7:0];
            end else begin
                oLCD_R <= 8'h00;
                oLCD_G <= 8'h00;
                oLCD_B <= 8'h00;
            end
            if (w_underflow_evt) begin
                oUNDERFLOW <= 1'b1;
            end
        end
    end

endmodule
